// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types and constants for the divide-ratio sequencer
package div_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  // 1 Hz output from a 12 MHz system clock
  localparam int unsigned DEF_DIV_RESET = 12000000;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/div_tick_gen.sv
// rtl/div_tick_gen.sv - period counter producing tick and wave for one divisor at a time
module div_tick_gen #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             hold,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_div,
  output logic             tick,
  output logic             wave,
  output logic             period_end
);
  logic [WIDTH-1:0] cnt, cur_div, cnt_n, div_n;
  logic             act, act_n, tick_q;

  assign period_end = act && !hold && (cnt == cur_div - WIDTH'(1));
  assign tick       = tick_q && !hold;

  always_comb begin
    cnt_n = cnt;
    div_n = cur_div;
    act_n = act;
    if (clear) begin
      act_n = 1'b0;
      cnt_n = '0;
    end else if (init) begin
      act_n = 1'b1;
      cnt_n = '0;
      div_n = load_div;
    end else if (period_end) begin
      cnt_n = '0;
      if (load) div_n = load_div;
    end else if (act && !hold) begin
      cnt_n = cnt + WIDTH'(1);
    end
  end

  // tick/wave are registered from the next count so they line up with cnt itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      cur_div <= '0;
      act     <= 1'b0;
      tick_q  <= 1'b0;
      wave    <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      cur_div <= div_n;
      act     <= act_n;
      tick_q  <= act_n && (cnt_n == div_n - WIDTH'(1));
      wave    <= act_n && (cnt_n >= (div_n >> 1));
    end
  end

endmodule

// File: rtl/div_sched_ctrl.sv
// rtl/div_sched_ctrl.sv - divide-ratio table sequencer; optional pause input under DIVSCHED_PAUSE_EN
module div_sched_ctrl
  import div_sched_pkg::*;
#(
  parameter int          WIDTH   = 24,
  parameter int          DEPTH   = 4,
  parameter int          REP_W   = 8,
  parameter int unsigned DEF_DIV = DEF_DIV_RESET,
  localparam int         AW      = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIVSCHED_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic [AW:0]      seq_len,
  input  logic             cfg_wr,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [REP_W-1:0] cfg_rep,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             tick,
  output logic             wave,
  output logic             busy,
  output logic [AW-1:0]    idx,
  output logic             seq_done
);
  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic [REP_W-1:0] rep;
  } entry_t;

  state_t           state, state_n;
  entry_t           tbl [DEPTH];
  entry_t           ent0, ent_nxt;
  logic [REP_W-1:0] rep_left;
  logic [AW:0]      len, len_in;
  logic [AW-1:0]    idx_nxt;
  logic [WIDTH-1:0] load_div;
  logic             pause_eff, period_end, init, load, clear, wr_ok, wr_en;

`ifdef DIVSCHED_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  assign wr_ok    = cfg_wr && !cfg_ack;
  assign wr_en    = wr_ok && (cfg_div != '0);
  assign busy     = (state != S_IDLE);
  assign idx_nxt  = (({1'b0, idx} + (AW+1)'(1)) >= len) ? '0 : idx + AW'(1);
  assign load_div = (state == S_IDLE) ? ent0.div : ent_nxt.div;
  assign seq_done = tick && ({1'b0, idx} == len - (AW+1)'(1)) && (rep_left == '0);

  // write-first: a load in the same cycle as a write sees the new entry
  always_comb begin
    ent0    = tbl[0];
    ent_nxt = tbl[idx_nxt];
    if (wr_en && cfg_addr == '0)     ent0    = {cfg_div, cfg_rep};
    if (wr_en && cfg_addr == idx_nxt) ent_nxt = {cfg_div, cfg_rep};
  end

  always_comb begin
    if (seq_len == '0)                      len_in = (AW+1)'(1);
    else if (seq_len > (AW+1)'(DEPTH))      len_in = (AW+1)'(DEPTH);
    else                                    len_in = seq_len;
  end

  always_comb begin
    state_n = state;
    init    = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_RUN;
          init    = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) state_n = S_STOPPING;
        load = period_end && (rep_left == '0);
      end
      S_STOPPING: begin
        if (period_end) begin
          state_n = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len      <= (AW+1)'(1);
      idx      <= '0;
      rep_left <= '0;
    end else if (init) begin
      len      <= len_in;
      idx      <= '0;
      rep_left <= ent0.rep;
    end else if (clear) begin
      idx      <= '0;
      rep_left <= '0;
    end else if (load) begin
      idx      <= idx_nxt;
      rep_left <= ent_nxt.rep;
    end else if (period_end) begin
      rep_left <= rep_left - REP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= {WIDTH'(DEF_DIV), REP_W'(0)};
    end else begin
      cfg_ack <= wr_ok;
      cfg_err <= wr_ok && (cfg_div == '0);
      if (wr_en) tbl[cfg_addr] <= {cfg_div, cfg_rep};
    end
  end

  div_tick_gen #(.WIDTH(WIDTH)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .hold       (pause_eff),
    .load       (load),
    .clear      (clear),
    .load_div   (load_div),
    .tick       (tick),
    .wave       (wave),
    .period_end (period_end)
  );

endmodule

// File: tb/tb_div_sched_ctrl.sv
// tb/tb_div_sched_ctrl.sv - scoreboard bench for div_sched_ctrl (WIDTH=8, DEPTH=4, DEF_DIV=4)
module tb_div_sched_ctrl;
  localparam int WIDTH = 8, DEPTH = 4, REP_W = 8, DEF_DIV = 4, AW = 2;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [AW:0]      seq_len = 3'd1;
  logic [AW-1:0]    cfg_addr = '0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic [REP_W-1:0] cfg_rep = '0;
  logic             cfg_ack, cfg_err, tick, wave, busy, seq_done;
  logic [AW-1:0]    idx;
`ifdef DIVSCHED_PAUSE_EN
  logic             pause = 1'b0;
`endif

  typedef struct {
    int cyc;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   cyc = 0, total = 0, bad = 0;
  bit   mon_en = 1'b0;
  int   mdiv [DEPTH];
  int   mrep [DEPTH];

  div_sched_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_W(REP_W), .DEF_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DIVSCHED_PAUSE_EN
    .pause    (pause),
`endif
    .start    (start),
    .stop     (stop),
    .seq_len  (seq_len),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_div  (cfg_div),
    .cfg_rep  (cfg_rep),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .wave     (wave),
    .busy     (busy),
    .idx      (idx),
    .seq_done (seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  // scoreboard: every tick must match the next expected (cycle, seq_done) pair
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (tick) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tick_unexpected cyc=%0d", cyc);
        end else begin
          got = exp_q.pop_front();
          if (cyc != got.cyc || seq_done !== got.done) begin
            bad++;
            $display("FAIL tick_sb cyc=%0d want_cyc=%0d seq_done=%0b want=%0b",
                     cyc, got.cyc, seq_done, got.done);
          end
        end
      end else if (seq_done) begin
        total++;
        bad++;
        $display("FAIL seq_done_without_tick cyc=%0d", cyc);
      end
    end
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task expect_tick(input int c, input bit d);
    exp_t x;
    x.cyc  = c;
    x.done = d;
    exp_q.push_back(x);
  endtask

  task model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdiv[i] = DEF_DIV;
      mrep[i] = 0;
    end
  endtask

  task do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic push_seq(input int e, input int n, input int len);
    int t, i, r, d, l;
    l = (len == 0) ? 1 : len;
    t = e; i = 0; r = mrep[0]; d = mdiv[0];
    while (t + d - 1 < e + n) begin
      expect_tick(t + d - 1, (i == l - 1) && (r == 0));
      t += d;
      if (r == 0) begin
        i = (i + 1) % l;
        r = mrep[i];
        d = mdiv[i];
      end else begin
        r--;
      end
    end
  endtask

  task cfg_write(input int a, input int d, input int r);
    cfg_addr = AW'(a); cfg_div = WIDTH'(d); cfg_rep = REP_W'(r); cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    total++;
    if (cfg_ack !== 1'b1 || cfg_err !== (d == 0)) begin
      bad++;
      $display("FAIL cfg_handshake ack=%0b err=%0b want_ack=1 want_err=%0b", cfg_ack, cfg_err, d == 0);
    end
    if (d != 0) begin
      mdiv[a] = d;
      mrep[a] = r;
    end
    step();
  endtask

  task start_seq(input int len, output int e);
    seq_len = (AW+1)'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    e = cyc;
  endtask

  task finish_window(input string name);
    mon_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_ticks left=%0d want=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task stop_wait();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 300 && busy; i++) step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_timeout busy=%0b want=0", busy);
    end
  endtask

  task test_reset();
    do_reset();
    total++;
    if (busy !== 1'b0 || idx !== '0) begin
      bad++;
      $display("FAIL reset_state busy=%0b idx=%0d want 0/0", busy, idx);
    end
    total++;
    if (tick !== 1'b0 || wave !== 1'b0 || seq_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick tick=%0b wave=%0b seq_done=%0b want 0", tick, wave, seq_done);
    end
    total++;
    if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_cfg ack=%0b err=%0b want 0", cfg_ack, cfg_err);
    end
  endtask

  task test_basic();
    int e;
    logic exp_w;
    mon_en = 1'b1;
    start_seq(1, e);
    push_seq(e, 16, 1);
    for (int k = 0; k < 16; k++) begin
      exp_w = ((k % 4) >= 2);
      total++;
      if (wave !== exp_w) begin
        bad++;
        $display("FAIL basic_wave k=%0d wave=%0b want=%0b", k, wave, exp_w);
      end
      step();
    end
    finish_window("basic");
    stop_wait();
  endtask

  task test_table();
    int e;
    cfg_write(0, 3, 1);
    cfg_write(1, 5, 0);
    mon_en = 1'b1;
    start_seq(2, e);
    push_seq(e, 30, 2);
    repeat (30) step();
    finish_window("table");
    stop_wait();
  endtask

  task test_stop();
    int e;
    do_reset();
    cfg_write(0, 5, 0);
    mon_en = 1'b1;
    start_seq(1, e);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_tick(e + 4, 1'b1);
    step(); step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_busy_at_tick busy=%0b want=1", busy);
    end
    step();
    total++;
    if (busy !== 1'b0 || wave !== 1'b0 || idx !== '0) begin
      bad++;
      $display("FAIL stop_idle busy=%0b wave=%0b idx=%0d want 0/0/0", busy, wave, idx);
    end
    finish_window("stop");
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_stop_idle busy=%0b want=0", busy);
    end
  endtask

  task test_cfg_running();
    int e;
    do_reset();
    cfg_write(0, 3, 0);
    cfg_write(1, 4, 0);
    cfg_write(0, 0, 5);
    mon_en = 1'b1;
    start_seq(2, e);
    expect_tick(e + 2, 1'b0);
    expect_tick(e + 6, 1'b1);
    expect_tick(e + 8, 1'b0);
    expect_tick(e + 15, 1'b1);
    expect_tick(e + 17, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin
        cfg_addr = 2'd1; cfg_div = 8'd7; cfg_rep = '0; cfg_wr = 1'b1;
      end
      if (k == 6) begin
        cfg_addr = 2'd0; cfg_div = 8'd2; cfg_rep = '0; cfg_wr = 1'b1;
      end
      if (k == 5 || k == 7) begin
        cfg_wr = 1'b0;
        total++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
          bad++;
          $display("FAIL cfg_run_ack k=%0d ack=%0b err=%0b want 1/0", k, cfg_ack, cfg_err);
        end
      end
      step();
    end
    finish_window("cfg_running");
    stop_wait();
  endtask

  task test_cfg_hold();
    cfg_addr = 2'd3; cfg_div = 8'd9; cfg_rep = '0; cfg_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (cfg_ack !== ((k % 2) == 0)) begin
        bad++;
        $display("FAIL cfg_hold k=%0d ack=%0b want=%0b", k, cfg_ack, (k % 2) == 0);
      end
    end
    cfg_wr = 1'b0;
    step();
  endtask

  task test_div1_and_reset();
    int e;
    do_reset();
    cfg_write(0, 1, 0);
    start_seq(1, e);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (tick !== 1'b1 || wave !== 1'b1) begin
        bad++;
        $display("FAIL div1 k=%0d tick=%0b wave=%0b want 1/1", k, tick, wave);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    total++;
    if (tick !== 1'b0 || wave !== 1'b0 || busy !== 1'b0 || idx !== '0 || seq_done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset tick=%0b wave=%0b busy=%0b idx=%0d want 0", tick, wave, busy, idx);
    end
    rst_n = 1'b1;
    model_reset();
    step();
    mon_en = 1'b1;
    start_seq(0, e);
    push_seq(e, 12, 0);
    repeat (12) step();
    finish_window("after_reset");
    stop_wait();
  endtask

`ifdef DIVSCHED_PAUSE_EN
  task test_pause();
    int e;
    do_reset();
    mon_en = 1'b1;
    start_seq(1, e);
    expect_tick(e + 6, 1'b1);
    expect_tick(e + 10, 1'b1);
    expect_tick(e + 14, 1'b1);
    for (int k = 0; k < 16; k++) begin
      pause = (k >= 2 && k <= 4);
      step();
    end
    pause = 1'b0;
    finish_window("pause");
    stop_wait();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_table();
    test_stop();
    test_cfg_running();
    test_cfg_hold();
    test_div1_and_reset();
`ifdef DIVSCHED_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
